// File: rtl/xnor_pkg.sv
// Shared types and helpers for the XNOR cross-channel accumulator.
//   acc_width()  : accumulator width that cannot overflow for a given psum width and channel count
//   acc_state_t  : pass-level FSM state
package xnor_pkg;

    // One sign bit of headroom on top of log2(channels) growth.
    function automatic int unsigned acc_width(input int unsigned psum_w,
                                              input int unsigned channels);
        return psum_w + $clog2(channels) + 1;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain
    } acc_state_t;

endpackage

// File: rtl/xnor_channel_accumulator_if.sv
// Streaming bus of the cross-channel accumulator.
//   psum_valid/psum_ready/psum_in          : partial-sum input beats (channel-major)
//   out_valid/out_ready/binary_out/out_acc : per-pixel result beats
// master = producer of partial sums / consumer of results; slave = the accumulator.
interface xnor_channel_accumulator_if #(
    parameter int unsigned PSUM_W = 5,
    parameter int unsigned ACC_W  = 14
);
    logic                     psum_valid;
    logic signed [PSUM_W-1:0] psum_in;
    logic                     psum_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic                     binary_out;
    logic signed [ACC_W-1:0]  out_acc;

    modport master (
        output psum_valid, psum_in, out_ready,
        input  psum_ready, out_valid, binary_out, out_acc
    );

    modport slave (
        input  psum_valid, psum_in, out_ready,
        output psum_ready, out_valid, binary_out, out_acc
    );
endinterface

// File: rtl/psum_line_buffer.sv
// Per-pixel running-sum storage.
//   clk              : clock
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr    : synchronous read request; dout holds its value while rd_en is low
//   dout             : read data, valid the cycle after rd_en
// Plain array so synthesis can map it to block or distributed RAM; no reset on purpose.
module psum_line_buffer #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned WIDTH  = 14,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  dout
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            dout <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/xnor_channel_accumulator.sv
// Cross-channel accumulator and binariser behind the XNOR PE array.
// Sums signed partial sums over NUM_CHANNELS channels per pixel (channel-major input order),
// keeps running sums in a line buffer and, on the last channel, emits the full sum plus a
// thresholded activation bit per pixel.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begin a tile pass (ignored while busy)
//   threshold, invert : compare threshold and result inversion, latched on accepted start
//   bus (slave)       : psum input stream and result output stream
//   busy              : pass in progress
//   done              : one-cycle pulse after the final output handshake
module xnor_channel_accumulator
    import xnor_pkg::*;
#(
    parameter int unsigned PSUM_W       = 5,
    parameter int unsigned NUM_PIXELS   = 1024,
    parameter int unsigned NUM_CHANNELS = 256,
    parameter int unsigned ACC_W        = acc_width(PSUM_W, NUM_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [ACC_W-1:0] threshold,
    input  logic                    invert,
    output logic                    busy,
    output logic                    done,
    xnor_channel_accumulator_if.slave bus
);
    localparam int unsigned PIX_W = $clog2(NUM_PIXELS);
    localparam int unsigned CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIXELS - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);

    acc_state_t              state_q;
    logic [PIX_W-1:0]        pix_cnt_q;
    logic [CH_W-1:0]         ch_cnt_q;
    logic signed [ACC_W-1:0] thr_q;
    logic                    inv_q;
    logic                    done_q;

    logic                     s1_valid_q;
    logic                     s1_first_q;
    logic                     s1_last_q;
    logic signed [PSUM_W-1:0] s1_psum_q;
    logic [PIX_W-1:0]         s1_pix_q;

    logic                    out_valid_q;
    logic                    binary_q;
    logic signed [ACC_W-1:0] out_acc_q;

    logic                    stall;
    logic                    accept;
    logic                    s1_fire;
    logic                    out_load;
    logic                    wr_en;
    logic                    final_beat;
    logic                    drain_done;
    logic [ACC_W-1:0]        buf_rd;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] sum;

    // A last-channel beat in S1 cannot move while the output register is still occupied.
    assign stall          = s1_valid_q && s1_last_q && out_valid_q && !bus.out_ready;
    assign bus.psum_ready = (state_q == StAccum) && !stall;
    assign accept         = bus.psum_valid && bus.psum_ready;
    assign s1_fire        = s1_valid_q && !stall;
    assign out_load       = s1_fire && s1_last_q;
    assign wr_en          = s1_fire && !s1_last_q;
    assign final_beat     = accept && (pix_cnt_q == PIX_LAST) && (ch_cnt_q == CH_LAST);
    assign drain_done     = (state_q == StDrain) && !s1_valid_q && out_valid_q && bus.out_ready;

    always_comb begin
        addend = s1_first_q ? '0 : $signed(buf_rd);
        sum    = ACC_W'(s1_psum_q) + addend;
    end

    // Same pixel is re-read NUM_PIXELS >= 2 beats after its write, so no bypass path.
    psum_line_buffer #(
        .DEPTH (NUM_PIXELS),
        .WIDTH (ACC_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (s1_pix_q),
        .wr_data (sum),
        .rd_en   (accept),
        .rd_addr (pix_cnt_q),
        .dout    (buf_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pix_cnt_q <= '0;
            ch_cnt_q  <= '0;
            thr_q     <= '0;
            inv_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        thr_q     <= threshold;
                        inv_q     <= invert;
                        pix_cnt_q <= '0;
                        ch_cnt_q  <= '0;
                        state_q   <= StAccum;
                    end
                end
                StAccum: begin
                    if (accept) begin
                        if (pix_cnt_q == PIX_LAST) begin
                            pix_cnt_q <= '0;
                            ch_cnt_q  <= (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + 1'b1;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + 1'b1;
                        end
                    end
                    if (final_beat) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_done) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // S1: beat, pixel index and channel-position flags; buffer read lands alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_psum_q  <= '0;
            s1_pix_q   <= '0;
        end else if (!stall) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_psum_q  <= bus.psum_in;
                s1_pix_q   <= pix_cnt_q;
                s1_first_q <= (ch_cnt_q == '0);
                s1_last_q  <= (ch_cnt_q == CH_LAST);
            end
        end
    end

    // Output register: a new result may replace the old one on its handshake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            binary_q    <= 1'b0;
        end else if (out_load) begin
            out_valid_q <= 1'b1;
            out_acc_q   <= sum;
            binary_q    <= (sum > thr_q) ^ inv_q;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_acc    = out_acc_q;
    assign bus.binary_out = binary_q;
    assign busy           = (state_q != StIdle);
    assign done           = done_q;

endmodule
